// File: rtl/fpu_pkg.sv
// Shared float_alu command encodings, command word layout and issue FSM states.
package fpu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;

  localparam logic RM_NEAREST_EVEN = 1'b0;
  localparam logic RM_TOWARD_ZERO  = 1'b1;

  // Flag vector is XZOUI, X in the MSB.
  localparam int FLAG_X = 4;
  localparam int FLAG_Z = 3;
  localparam int FLAG_O = 2;
  localparam int FLAG_U = 1;
  localparam int FLAG_I = 0;

  localparam int CMD_TAG_W = 4;

  typedef struct packed {
    logic [CMD_TAG_W-1:0] tag;
    logic [2:0]           op_code;
    logic                 round_mode;
    logic                 mode_fp;
    logic [31:0]          op_a;
    logic [31:0]          op_b;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with show-ahead head, 1-cycle write-to-read latency; push ignored when full,
// pop ignored when empty, clear drops contents (and any same-cycle push) at the edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fpu_issue_queue.sv
// Queues core FP requests and issues them to float_alu at most once per 3 cycles, capped at MAX_INFLIGHT
// outstanding; results pass straight through with their tag, backpressure from res_ready goes to the ALU.
module fpu_issue_queue import fpu_pkg::*; #(
  parameter int DEPTH        = 4,
  parameter int MAX_INFLIGHT = 2,
  parameter int TAG_W        = CMD_TAG_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [TAG_W-1:0]              cmd_tag,
  input  logic [2:0]                    cmd_op_code,
  input  logic                          cmd_round_mode,
  input  logic                          cmd_mode_fp,
  input  logic [31:0]                   cmd_op_a,
  input  logic [31:0]                   cmd_op_b,
  output logic                          alu_start,
  output logic [31:0]                   alu_op_a,
  output logic [31:0]                   alu_op_b,
  output logic [2:0]                    alu_op_code,
  output logic                          alu_round_mode,
  output logic                          alu_mode_fp,
  input  logic                          alu_ready_out,
  input  logic                          alu_valid_out,
  input  logic [31:0]                   alu_result,
  input  logic [4:0]                    alu_flags,
  output logic                          alu_ready_in,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [31:0]                   res_data,
  output logic [4:0]                    res_flags,
  output logic [TAG_W-1:0]              res_tag,
  output logic [$clog2(DEPTH):0]        queue_count,
  output logic [$clog2(MAX_INFLIGHT):0] inflight,
  output logic                          err_orphan
);

  // Tag FIFO is rounded up to a power of two >= 2; the inflight cap keeps it from ever filling past MAX_INFLIGHT.
  localparam int TAG_DEPTH = (MAX_INFLIGHT < 2) ? 2 : (1 << $clog2(MAX_INFLIGHT));
  localparam int IW        = $clog2(MAX_INFLIGHT) + 1;
  localparam int TCW       = $clog2(TAG_DEPTH) + 1;
  localparam logic [IW-1:0] MAX_IF = IW'(MAX_INFLIGHT);

  state_t           state;
  state_t           state_nxt;
  cmd_t             cmd_in;
  cmd_t             cmd_head;
  logic             cmd_full;
  logic             cmd_empty;
  logic             cmd_push;
  logic             issue;
  logic [TAG_W-1:0] tag_head;
  logic             tag_full;
  logic             tag_empty;
  logic             tag_pop;
  logic [TCW-1:0]   tag_count;

  assign cmd_in = '{tag: cmd_tag, op_code: cmd_op_code, round_mode: cmd_round_mode,
                    mode_fp: cmd_mode_fp, op_a: cmd_op_a, op_b: cmd_op_b};

  assign cmd_ready = !cmd_full && !rst;
  assign cmd_push  = cmd_valid && cmd_ready;
  assign issue     = (state == S_IDLE) && !cmd_empty && alu_ready_out && (inflight < MAX_IF)
                     && !tag_full && !flush && !rst;

  sync_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(DEPTH)) u_cmd_fifo (
    .clk(clk), .rst(rst), .clear(flush),
    .push(cmd_push), .push_data(cmd_in), .pop(issue), .pop_data(cmd_head),
    .full(cmd_full), .empty(cmd_empty), .count(queue_count)
  );

  // An orphan result (no tag in flight) must not pop, otherwise the counter would underflow.
  assign tag_pop = alu_valid_out && res_ready && !tag_empty;

  sync_fifo #(.WIDTH(TAG_W), .DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk(clk), .rst(rst), .clear(1'b0),
    .push(issue), .push_data(cmd_head.tag), .pop(tag_pop), .pop_data(tag_head),
    .full(tag_full), .empty(tag_empty), .count(tag_count)
  );

  assign inflight = IW'(tag_count);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (issue) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_GAP;
      S_GAP:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    alu_start = (state == S_ISSUE) && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_op_a       <= '0;
      alu_op_b       <= '0;
      alu_op_code    <= '0;
      alu_round_mode <= 1'b0;
      alu_mode_fp    <= 1'b0;
    end else if (issue) begin
      alu_op_a       <= cmd_head.op_a;
      alu_op_b       <= cmd_head.op_b;
      alu_op_code    <= cmd_head.op_code;
      alu_round_mode <= cmd_head.round_mode;
      alu_mode_fp    <= cmd_head.mode_fp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                            err_orphan <= 1'b0;
    else if (alu_valid_out && tag_empty) err_orphan <= 1'b1;
  end

  assign res_valid    = alu_valid_out;
  assign alu_ready_in = res_ready;
  assign res_data     = alu_result;
  assign res_flags    = alu_flags;
  assign res_tag      = tag_empty ? '0 : tag_head;

endmodule
